// File: rtl/vga_axil_regfile_if.sv
// AXI4-Lite bus bundle between a master and the VGA register file.
// Master drives AW/W/AR payloads and B/R ready; slave drives the rest.
interface vga_axil_regfile_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned STRB_W = DATA_W / 8;

  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/vga_axil_regfile.sv
// AXI4-Lite slave register file holding VGA timing/colour configuration.
// AW and W are captured in independent one-entry slots and may arrive in any
// order; a same-cycle handshake bypasses the slot so B follows one cycle later.
// Optional macro VGA_AXIL_REGFILE_WR_PULSE_EN adds a one-cycle per-register
// write strobe output wr_pulse_o.
module vga_axil_regfile #(
  parameter int unsigned          ADDR_W    = 32,
  parameter int unsigned          DATA_W    = 32,
  parameter int unsigned          NUM_REGS  = 8,
  parameter logic [ADDR_W-1:0]    BASE_ADDR = '0,
  parameter logic [DATA_W-1:0]    RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         arst,
  vga_axil_regfile_if.slave            bus,
  output logic [NUM_REGS*DATA_W-1:0]   regs_o
`ifdef VGA_AXIL_REGFILE_WR_PULSE_EN
  ,
  output logic [NUM_REGS-1:0]          wr_pulse_o
`endif
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned LSB    = $clog2(STRB_W);
  localparam int unsigned IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Register array and handshake state
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  logic              aw_full_q, aw_full_d;
  logic [ADDR_W-1:0] aw_addr_q, aw_addr_d;
  logic              w_full_q,  w_full_d;
  logic [DATA_W-1:0] w_data_q,  w_data_d;
  logic [STRB_W-1:0] w_strb_q,  w_strb_d;

  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q,  bresp_d;
  logic              rvalid_q, rvalid_d;
  logic [1:0]        rresp_q,  rresp_d;
  logic [DATA_W-1:0] rdata_q,  rdata_d;

`ifdef VGA_AXIL_REGFILE_WR_PULSE_EN
  logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;
`endif

  // Address relative to BASE_ADDR with a borrow bit flagging addr < BASE_ADDR
  function automatic logic [ADDR_W:0] rel_addr(input logic [ADDR_W-1:0] a);
    return {1'b0, a} - {1'b0, BASE_ADDR};
  endfunction

  logic              aw_hs, w_hs, ar_hs;
  logic              aw_avail, w_avail, commit;
  logic [ADDR_W-1:0] cur_awaddr;
  logic [DATA_W-1:0] cur_wdata;
  logic [STRB_W-1:0] cur_wstrb;
  logic [ADDR_W:0]   wr_rel, rd_rel;
  logic [ADDR_W-1:0] wr_word, rd_word;
  logic              wr_err, rd_err;
  logic [IDX_W-1:0]  wr_idx, rd_idx;

  // Ready outputs held low while reset is asserted
  assign bus.awready = !arst && !aw_full_q;
  assign bus.wready  = !arst && !w_full_q;
  assign bus.arready = !arst && (!rvalid_q || bus.rready);

  assign bus.bvalid = bvalid_q;
  assign bus.bresp  = bresp_q;
  assign bus.rvalid = rvalid_q;
  assign bus.rresp  = rresp_q;
  assign bus.rdata  = rdata_q;

`ifdef VGA_AXIL_REGFILE_WR_PULSE_EN
  assign wr_pulse_o = wr_pulse_q;
`endif

  // Flatten the register array onto the configuration bus
  always_comb begin
    regs_o = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      regs_o[i*DATA_W +: DATA_W] = regs_q[i];
    end
  end

  // Handshakes, decode, write commit and read response next-state
  always_comb begin
    aw_hs = bus.awvalid && bus.awready;
    w_hs  = bus.wvalid  && bus.wready;
    ar_hs = bus.arvalid && bus.arready;

    aw_avail   = aw_full_q || aw_hs;
    w_avail    = w_full_q  || w_hs;
    cur_awaddr = aw_full_q ? aw_addr_q : bus.awaddr;
    cur_wdata  = w_full_q  ? w_data_q  : bus.wdata;
    cur_wstrb  = w_full_q  ? w_strb_q  : bus.wstrb;
    commit     = aw_avail && w_avail && (!bvalid_q || bus.bready);

    wr_rel  = rel_addr(cur_awaddr);
    wr_word = wr_rel[ADDR_W-1:0] >> LSB;
    wr_err  = wr_rel[ADDR_W] || (wr_word >= ADDR_W'(NUM_REGS));
    wr_idx  = IDX_W'(wr_word);

    rd_rel  = rel_addr(bus.araddr);
    rd_word = rd_rel[ADDR_W-1:0] >> LSB;
    rd_err  = rd_rel[ADDR_W] || (rd_word >= ADDR_W'(NUM_REGS));
    rd_idx  = IDX_W'(rd_word);

    regs_d    = regs_q;
    aw_full_d = commit ? 1'b0 : aw_avail;
    aw_addr_d = aw_hs ? bus.awaddr : aw_addr_q;
    w_full_d  = commit ? 1'b0 : w_avail;
    w_data_d  = w_hs ? bus.wdata : w_data_q;
    w_strb_d  = w_hs ? bus.wstrb : w_strb_q;
    bvalid_d  = bvalid_q && !bus.bready;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q && !bus.rready;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
`ifdef VGA_AXIL_REGFILE_WR_PULSE_EN
    wr_pulse_d = '0;
`endif

    if (commit) begin
      bvalid_d = 1'b1;
      bresp_d  = wr_err ? RESP_SLVERR : RESP_OKAY;
      if (!wr_err) begin
        for (int unsigned b = 0; b < STRB_W; b++) begin
          if (cur_wstrb[b]) begin
            regs_d[wr_idx][b*8 +: 8] = cur_wdata[b*8 +: 8];
          end
        end
`ifdef VGA_AXIL_REGFILE_WR_PULSE_EN
        if (|cur_wstrb) begin
          wr_pulse_d[wr_idx] = 1'b1;
        end
`endif
      end
    end

    // Reads sample regs_q, so a same-edge write is not visible yet
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rresp_d  = rd_err ? RESP_SLVERR : RESP_OKAY;
      rdata_d  = rd_err ? '0 : regs_q[rd_idx];
    end
  end

  // State registers
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= RESET_VAL;
      end
      aw_full_q <= 1'b0;
      aw_addr_q <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
`ifdef VGA_AXIL_REGFILE_WR_PULSE_EN
      wr_pulse_q <= '0;
`endif
    end else begin
      regs_q    <= regs_d;
      aw_full_q <= aw_full_d;
      aw_addr_q <= aw_addr_d;
      w_full_q  <= w_full_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
`ifdef VGA_AXIL_REGFILE_WR_PULSE_EN
      wr_pulse_q <= wr_pulse_d;
`endif
    end
  end

endmodule

// File: tb/tb_vga_axil_regfile.sv
// Directed bench for vga_axil_regfile: ordering of AW/W, strobes, decode
// errors, B backpressure, read/write collision and mid-transaction reset.
module tb_vga_axil_regfile;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned NUM_REGS = 8;
  localparam logic [31:0] BASE     = 32'h0000_0040;
  localparam logic [31:0] RST_VAL  = 32'hA5A5_5A5A;
  localparam logic [1:0]  OKAY     = 2'b00;
  localparam logic [1:0]  SLVERR   = 2'b10;

  logic clk;
  logic arst;
  logic [NUM_REGS*DATA_W-1:0] regs;
`ifdef VGA_AXIL_REGFILE_WR_PULSE_EN
  logic [NUM_REGS-1:0] wr_pulse;
`endif

  vga_axil_regfile_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  vga_axil_regfile #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS),
    .BASE_ADDR(BASE), .RESET_VAL(RST_VAL)
  ) dut (
    .clk(clk),
    .arst(arst),
    .bus(bus),
    .regs_o(regs)
`ifdef VGA_AXIL_REGFILE_WR_PULSE_EN
    ,
    .wr_pulse_o(wr_pulse)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_r [NUM_REGS];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < NUM_REGS; i++) begin
      check($sformatf("%s_reg%0d", tag, i), 64'(regs[i*DATA_W +: DATA_W]), 64'(exp_r[i]));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Full write with AW and W presented together; returns the B response
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, output logic [1:0] resp);
    bit aw_done, w_done, got_b, aw_go, w_go;
    aw_done = 0; w_done = 0; got_b = 0;
    resp = 2'b11;
    bus.awaddr = addr; bus.awvalid = 1'b1;
    bus.wdata = data; bus.wstrb = strb; bus.wvalid = 1'b1;
    for (int n = 0; n < 20 && !(aw_done && w_done); n++) begin
      aw_go = bus.awvalid && bus.awready;
      w_go  = bus.wvalid && bus.wready;
      cycle();
      if (aw_go) begin bus.awvalid = 1'b0; aw_done = 1; end
      if (w_go)  begin bus.wvalid  = 1'b0; w_done  = 1; end
    end
    check("wr_handshake", 64'({aw_done, w_done}), 64'(2'b11));
    for (int n = 0; n < 20 && !got_b; n++) begin
      if (bus.bvalid) begin
        resp = bus.bresp;
        got_b = 1;
      end else begin
        cycle();
      end
    end
    check("wr_bvalid", 64'(got_b), 64'(1));
    cycle();
  endtask

  // Single read; checks the one-cycle response latency
  task automatic do_read(input logic [31:0] addr, output logic [31:0] data,
                         output logic [1:0] resp);
    bit done, go;
    done = 0;
    data = 32'hxxxx_xxxx; resp = 2'b11;
    bus.araddr = addr; bus.arvalid = 1'b1;
    for (int n = 0; n < 20 && !done; n++) begin
      go = bus.arready;
      cycle();
      if (go) begin
        bus.arvalid = 1'b0;
        done = 1;
      end
    end
    check("rd_handshake", 64'(done), 64'(1));
    check("rd_latency", 64'(bus.rvalid), 64'(1));
    data = bus.rdata;
    resp = bus.rresp;
    cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  logic [31:0] rd;
  logic [1:0]  rsp;

  initial begin
    arst = 1'b1;
    bus.awaddr = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b1;
    bus.araddr = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b1;
    for (int i = 0; i < NUM_REGS; i++) exp_r[i] = RST_VAL;

    // Reset state
    @(negedge clk);
    check("rst_awready", 64'(bus.awready), 64'(0));
    check("rst_wready",  64'(bus.wready),  64'(0));
    check("rst_arready", 64'(bus.arready), 64'(0));
    check("rst_bvalid",  64'(bus.bvalid),  64'(0));
    check("rst_rvalid",  64'(bus.rvalid),  64'(0));
    check("rst_rdata",   64'(bus.rdata),   64'(0));
    arst = 1'b0;
    cycle();
    check("post_rst_awready", 64'(bus.awready), 64'(1));
    check("post_rst_arready", 64'(bus.arready), 64'(1));
    check_regs("rst");

    // AW+W same cycle to reg 2: B visible the next cycle
    bus.awaddr = BASE + 32'h8; bus.awvalid = 1'b1;
    bus.wdata = 32'hDEAD_BEEF; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    check("sc_awready", 64'(bus.awready), 64'(1));
    check("sc_wready",  64'(bus.wready),  64'(1));
    cycle();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    exp_r[2] = 32'hDEAD_BEEF;
    check("sc_bvalid", 64'(bus.bvalid), 64'(1));
    check("sc_bresp",  64'(bus.bresp),  64'(OKAY));
    check_regs("sc");
`ifdef VGA_AXIL_REGFILE_WR_PULSE_EN
    check("sc_pulse", 64'(wr_pulse), 64'(8'h04));
`endif
    cycle();
    check("sc_bvalid_clr", 64'(bus.bvalid), 64'(0));
`ifdef VGA_AXIL_REGFILE_WR_PULSE_EN
    check("sc_pulse_clr", 64'(wr_pulse), 64'(0));
`endif

    // W three cycles before AW, partial strobes
    bus.wdata = 32'h1122_3344; bus.wstrb = 4'b0101; bus.wvalid = 1'b1;
    cycle();
    bus.wvalid = 1'b0;
    check("wfirst_wready_full", 64'(bus.wready), 64'(0));
    check("wfirst_no_b0", 64'(bus.bvalid), 64'(0));
    cycle();
    cycle();
    check("wfirst_no_b2", 64'(bus.bvalid), 64'(0));
    bus.awaddr = BASE + 32'h8; bus.awvalid = 1'b1;
    cycle();
    bus.awvalid = 1'b0;
    exp_r[2] = 32'hDE22_BE44;
    check("wfirst_bvalid", 64'(bus.bvalid), 64'(1));
    check("wfirst_bresp",  64'(bus.bresp),  64'(OKAY));
    check("wfirst_reg2",   64'(regs[2*DATA_W +: DATA_W]), 64'(32'hDE22_BE44));
    cycle();
    check("wfirst_single_b", 64'(bus.bvalid), 64'(0));
    check("wfirst_wready", 64'(bus.wready), 64'(1));

    // Decode errors and address decode
    do_read(BASE + 32'h20, rd, rsp);
    check("oor_rresp", 64'(rsp), 64'(SLVERR));
    check("oor_rdata", 64'(rd),  64'(0));
    do_read(BASE - 32'h4, rd, rsp);
    check("below_rresp", 64'(rsp), 64'(SLVERR));
    do_write(BASE + 32'h20, 32'hFFFF_FFFF, 4'hF, rsp);
    check("oor_bresp", 64'(rsp), 64'(SLVERR));
    check_regs("oor_wr");
    do_read(BASE + 32'hB, rd, rsp);
    check("unaligned_rdata", 64'(rd),  64'(32'hDE22_BE44));
    check("unaligned_rresp", 64'(rsp), 64'(OKAY));

    // Zero strobes: OKAY with no change
    do_write(BASE + 32'h14, 32'h1234_5678, 4'h0, rsp);
    check("strb0_bresp", 64'(rsp), 64'(OKAY));
    check_regs("strb0");

    // B backpressure: second write parks in the slots until B completes
    bus.bready = 1'b0;
    bus.awaddr = BASE + 32'hC; bus.awvalid = 1'b1;
    bus.wdata = 32'h3333_3333; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    cycle();
    exp_r[3] = 32'h3333_3333;
    check("bp_bvalid", 64'(bus.bvalid), 64'(1));
    bus.awaddr = BASE + 32'h200; bus.wdata = 32'h4444_4444;
    check("bp_awready2", 64'(bus.awready), 64'(1));
    check("bp_wready2",  64'(bus.wready),  64'(1));
    cycle();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    check("bp_aw_full", 64'(bus.awready), 64'(0));
    check("bp_w_full",  64'(bus.wready),  64'(0));
    for (int i = 0; i < 4; i++) begin
      check($sformatf("bp_hold_valid%0d", i), 64'(bus.bvalid), 64'(1));
      check($sformatf("bp_hold_resp%0d", i),  64'(bus.bresp),  64'(OKAY));
      cycle();
    end
    bus.bready = 1'b1;
    cycle();
    check("bp_second_bvalid", 64'(bus.bvalid), 64'(1));
    check("bp_second_bresp",  64'(bus.bresp),  64'(SLVERR));
    check("bp_slot_free",     64'(bus.awready), 64'(1));
    cycle();
    check("bp_done", 64'(bus.bvalid), 64'(0));
    check_regs("bp");

    // Same-edge read and write to reg 0 returns the old value
    do_write(BASE, 32'h1, 4'hF, rsp);
    exp_r[0] = 32'h1;
    check("col_pre_bresp", 64'(rsp), 64'(OKAY));
    bus.araddr = BASE; bus.arvalid = 1'b1;
    bus.awaddr = BASE; bus.awvalid = 1'b1;
    bus.wdata = 32'h2; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    cycle();
    bus.arvalid = 1'b0; bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    exp_r[0] = 32'h2;
    check("col_rvalid", 64'(bus.rvalid), 64'(1));
    check("col_rdata",  64'(bus.rdata),  64'(32'h1));
    check("col_bvalid", 64'(bus.bvalid), 64'(1));
    check("col_reg0",   64'(regs[0 +: DATA_W]), 64'(32'h2));
    cycle();
    do_read(BASE, rd, rsp);
    check("col_after_rdata", 64'(rd), 64'(32'h2));

    // Reset while R is pending and the AW slot holds an address
    bus.rready = 1'b0;
    bus.araddr = BASE + 32'h8; bus.arvalid = 1'b1;
    bus.awaddr = BASE + 32'h4; bus.awvalid = 1'b1;
    cycle();
    bus.arvalid = 1'b0; bus.awvalid = 1'b0;
    check("mr_rvalid_pre",  64'(bus.rvalid),  64'(1));
    check("mr_aw_full_pre", 64'(bus.awready), 64'(0));
    arst = 1'b1;
    #1;
    for (int i = 0; i < NUM_REGS; i++) exp_r[i] = RST_VAL;
    check("mr_rvalid",  64'(bus.rvalid),  64'(0));
    check("mr_awready", 64'(bus.awready), 64'(0));
    check("mr_arready", 64'(bus.arready), 64'(0));
    check_regs("mr");
    cycle();
    arst = 1'b0;
    bus.rready = 1'b1;
    #1;
    check("mr_aw_empty", 64'(bus.awready), 64'(1));
    check("mr_w_empty",  64'(bus.wready),  64'(1));

    // W alone must not commit: the old AW slot was dropped
    bus.wdata = 32'h0000_CAFE; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    cycle();
    bus.wvalid = 1'b0;
    cycle();
    check("mr_no_stale_commit", 64'(bus.bvalid), 64'(0));
    bus.awaddr = BASE + 32'h4; bus.awvalid = 1'b1;
    cycle();
    bus.awvalid = 1'b0;
    exp_r[1] = 32'h0000_CAFE;
    check("mr_new_bvalid", 64'(bus.bvalid), 64'(1));
    check("mr_new_bresp",  64'(bus.bresp),  64'(OKAY));
    cycle();
    check_regs("mr_new");
    do_read(BASE + 32'h4, rd, rsp);
    check("mr_read_rdata", 64'(rd),  64'(32'h0000_CAFE));
    check("mr_read_rresp", 64'(rsp), 64'(OKAY));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
